// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg : screen-state encoding and BCD score helpers shared with frame mux
// Revision : 1.0
// ============================================================================
package game_pkg;

   typedef enum logic [1:0] {
      ST_START = 2'b00,
      ST_GAME  = 2'b01,
      ST_OVER  = 2'b10
   } game_state_t;

   localparam logic [7:0] SCORE_MAX = 8'h99;

   // Two-digit BCD increment that sticks at SCORE_MAX.
   function automatic logic [7:0] bcd_inc(input logic [7:0] value);
      logic [7:0] result;
      if (value >= SCORE_MAX)
         result = SCORE_MAX;
      else if (value[3:0] == 4'd9)
         result = {value[7:4] + 4'd1, 4'd0};
      else
         result = {value[7:4], value[3:0] + 4'd1};
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce : 2-FF synchroniser, stability counter, rising-edge press pulse
// Revision     : 1.0
// ============================================================================
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 65000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press_evt
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync0;
   logic          sync1;
   logic          level;
   logic          level_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0     <= 1'b0;
         sync1     <= 1'b0;
         level     <= 1'b0;
         level_q   <= 1'b0;
         cnt       <= '0;
         press_evt <= 1'b0;
      end else begin
         sync0     <= btn;
         sync1     <= sync0;
         level_q   <= level;
         press_evt <= level & ~level_q;
         // Any disagreement that does not last the full window restarts the count.
         if (sync1 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync1;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/game_state_ctrl.sv
`default_nettype none
// ============================================================================
// game_state_ctrl : frame-aligned game sequencer with debounced flap and BCD score
// Revision        : 1.0
// ============================================================================
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 65000,
   parameter int HOLDOFF_FRAMES  = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       btn,
   input  logic       collision,
   input  logic       pipe_passed,
   output logic [1:0] state,
   output logic       game_rst,
   output logic       flap,
   output logic [7:0] score,
   output logic [7:0] best
);

   localparam int HW = $clog2(HOLDOFF_FRAMES + 2);

   game_state_t   state_q;
   game_state_t   state_d;
   game_state_t   target;
   logic          req_q;
   logic          req_d;
   logic          req_now;
   logic          raise;
   logic          illegal;
   logic          commit;
   logic          enter_game;
   logic          enter_over;
   logic          flap_d;
   logic [7:0]    score_d;
   logic [HW-1:0] holdoff;
   logic          press_evt;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (btn),
      .press_evt (press_evt)
   );

   always_comb begin
      raise   = 1'b0;
      target  = ST_START;
      illegal = 1'b0;
      case (state_q)
         ST_START: begin
            raise  = press_evt;
            target = ST_GAME;
         end
         ST_GAME: begin
            raise  = collision;
            target = ST_OVER;
         end
         ST_OVER: begin
            raise  = press_evt && (holdoff == '0);
            target = ST_START;
         end
         default: illegal = 1'b1;
      endcase

      // The single pending bit always targets the successor of the current state.
      req_now    = req_q | raise;
      commit     = frame_tick & req_now & ~illegal;
      enter_game = commit && (state_q == ST_START);
      enter_over = commit && (state_q == ST_GAME);

      state_d = state_q;
      req_d   = req_now;
      if (illegal) begin
         state_d = ST_START;
         req_d   = 1'b0;
      end else if (commit) begin
         state_d = target;
         req_d   = 1'b0;
      end

      score_d = score;
      if (enter_game)
         score_d = 8'h00;
      else if ((state_q == ST_GAME) && pipe_passed && !req_q)
         score_d = bcd_inc(score);

      flap_d = press_evt && (state_q == ST_GAME) && !req_now;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_START;
         req_q    <= 1'b0;
         holdoff  <= '0;
         score    <= 8'h00;
         best     <= 8'h00;
         game_rst <= 1'b0;
         flap     <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         score    <= score_d;
         game_rst <= enter_game;
         flap     <= flap_d;
         if (enter_over) begin
            best    <= (score_d > best) ? score_d : best;
            holdoff <= HW'(HOLDOFF_FRAMES);
         end else if (frame_tick && (holdoff != '0)) begin
            holdoff <= holdoff - HW'(1);
         end
      end
   end

   assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
`default_nettype none
// ============================================================================
// tb_game_state_ctrl : directed self-checking bench for game_state_ctrl
// Revision           : 1.0
// ============================================================================
module tb_game_state_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       btn = 1'b0;
   logic       collision = 1'b0;
   logic       pipe_passed = 1'b0;
   logic [1:0] state;
   logic       game_rst;
   logic       flap;
   logic [7:0] score;
   logic [7:0] best;

   int tests = 0;
   int fails = 0;
   int tick_div = 0;
   int flap_cnt = 0;
   int flap_base = 0;

   game_state_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .HOLDOFF_FRAMES  (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_tick  (frame_tick),
      .btn         (btn),
      .collision   (collision),
      .pipe_passed (pipe_passed),
      .state       (state),
      .game_rst    (game_rst),
      .flap        (flap),
      .score       (score),
      .best        (best)
   );

   always #5 clk = ~clk;

   // Frame tick: one cycle in every 20, changed on the falling edge.
   always @(negedge clk) begin
      if (tick_div == 19) begin
         frame_tick = 1'b1;
         tick_div   = 0;
      end else begin
         frame_tick = 1'b0;
         tick_div++;
      end
   end

   always @(negedge clk) begin
      if (flap) flap_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Returns one cycle after a frame tick, i.e. once any commit is visible.
   task automatic wait_tick();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (frame_tick) seen = 1'b1;
      end
      check("tick_wait", {7'd0, seen}, 8'd1);
      step();
   endtask

   task automatic press();
      btn = 1'b1;
      repeat (10) step();
      btn = 1'b0;
      repeat (4) step();
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         pipe_passed = 1'b1;
         step();
         pipe_passed = 1'b0;
         step();
      end
   endtask

   task automatic start_game();
      wait_tick();
      press();
      check("start_deferred", {6'd0, state}, 8'h00);
      wait_tick();
      check("enter_game_state", {6'd0, state}, 8'h01);
      check("enter_game_rst", {7'd0, game_rst}, 8'd1);
      check("enter_game_score", score, 8'h00);
      step();
      check("game_rst_one_cycle", {7'd0, game_rst}, 8'd0);
   endtask

   // Collision followed by a pipe pulse that must be ignored; commits at next tick.
   task automatic crash(input logic [7:0] exp_score);
      wait_tick();
      collision = 1'b1;
      step();
      collision = 1'b0;
      pulses(1);
      check("pipe_after_over_req", score, exp_score);
      check("over_deferred", {6'd0, state}, 8'h01);
      wait_tick();
   endtask

   initial begin
      repeat (3) step();
      check("rst_state", {6'd0, state}, 8'h00);
      check("rst_score", score, 8'h00);
      check("rst_best", best, 8'h00);
      check("rst_game_rst", {7'd0, game_rst}, 8'd0);
      check("rst_flap", {7'd0, flap}, 8'd0);
      rst_n = 1'b1;
      step();

      start_game();
      pulses(12);
      check("score_12", score, 8'h12);

      // Asynchronous reset mid-round.
      rst_n = 1'b0;
      #1;
      check("midrst_state", {6'd0, state}, 8'h00);
      check("midrst_score", score, 8'h00);
      check("midrst_best", best, 8'h00);
      check("midrst_game_rst", {7'd0, game_rst}, 8'd0);
      step();
      check("midrst_no_game_rst", {7'd0, game_rst}, 8'd0);
      rst_n = 1'b1;
      step();

      start_game();
      pulses(5);
      check("score_05", score, 8'h05);
      crash(8'h05);
      check("over1_state", {6'd0, state}, 8'h02);
      check("over1_best", best, 8'h05);
      check("over1_score", score, 8'h05);

      // Holdoff: presses in the first frames after OVER are dropped, not queued.
      flap_base = flap_cnt;
      press();
      wait_tick();
      check("holdoff_f1", {6'd0, state}, 8'h02);
      press();
      wait_tick();
      check("holdoff_f2", {6'd0, state}, 8'h02);
      wait_tick();
      check("holdoff_not_queued", {6'd0, state}, 8'h02);
      press();
      wait_tick();
      check("over_to_start", {6'd0, state}, 8'h00);

      start_game();
      check("flap_none_start_over", flap_cnt - flap_base, 0);
      check("best_kept_in_game", best, 8'h05);
      pulses(7);
      crash(8'h07);
      check("over2_state", {6'd0, state}, 8'h02);
      check("over2_best", best, 8'h07);
      check("over2_score_held", score, 8'h07);
      repeat (3) wait_tick();
      press();
      wait_tick();
      check("over2_to_start", {6'd0, state}, 8'h00);

      start_game();
      pulses(98);
      check("score_98", score, 8'h98);
      pulses(1);
      check("score_99", score, 8'h99);
      pulses(2);
      check("score_sat", score, 8'h99);
      check("best_not_live", best, 8'h07);

      // Bouncy button then a long hold: exactly one flap.
      flap_base = flap_cnt;
      repeat (6) begin
         btn = 1'b1;
         repeat (2) step();
         btn = 1'b0;
         repeat (2) step();
      end
      check("bounce_no_flap", flap_cnt - flap_base, 0);
      btn = 1'b1;
      repeat (50) step();
      btn = 1'b0;
      repeat (20) step();
      check("bounce_one_flap", flap_cnt - flap_base, 1);
      check("bounce_state", {6'd0, state}, 8'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
